// File: rtl/uart_peer_pkg.sv
// Shared types and helpers for the uart_peer receive block.
// Build option: UART_PEER_PARITY_EN adds an even-parity bit between data and stop.
package uart_peer_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PEER_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } rx_state_t;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_peer_fifo.sv
// Small synchronous FIFO; pointers carry one extra MSB so full and empty
// are told apart without a separate flag.
module uart_peer_fifo
  import uart_peer_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = UART_DATA_BITS,
  localparam int AW    = $clog2(DEPTH),
  localparam int PTR_W = AW + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             push_ok;
  logic             pop_ok;

  assign count_o    = wr_ptr_q - rd_ptr_q;
  assign full_o     = (count_o == PTR_W'(DEPTH));
  assign empty_o    = (count_o == '0);
  assign pop_ok     = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a push on full still lands.
  assign push_ok    = push_i & (~full_o | pop_ok);
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: storage is reset on purpose so the head output reads 0 out of reset;
  // state updates use non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        wr_ptr_q                <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

endmodule

// File: rtl/uart_peer_rx.sv
// Receive-side UART peer: synchroniser, frame FSM and receive FIFO with rts.
// Build option: UART_PEER_PARITY_EN selects 8E1 framing, otherwise 8N1.
module uart_peer_rx
  import uart_peer_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rxd,
  output logic       rts,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       framing_error,
  output logic       overrun_error,
  output logic       parity_error
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(UART_DATA_BITS);
  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLK_DIV - 1);

  logic                      rxd_meta_q;
  logic                      rxd_s_q;
  rx_state_t                 state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [BIT_W-1:0]          bit_cnt_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      rts_q;
`ifdef UART_PEER_PARITY_EN
  logic                      par_err_q;
`endif

  logic             expire;
  logic             stop_sample;
  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PTR_W-1:0] fifo_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  assign expire      = (cnt_q == '0);
  assign stop_sample = (state_q == STOP) && expire;

  // Push and error pulses are decoded in the stop-sample cycle itself, so
  // the byte lands in the FIFO at the same edge the FSM leaves STOP.
  assign fifo_push     = stop_sample &  rxd_s_q & ~fifo_full;
  assign overrun_error = stop_sample &  rxd_s_q &  fifo_full;
  assign framing_error = stop_sample & ~rxd_s_q;
`ifdef UART_PEER_PARITY_EN
  assign parity_error  = fifo_push & par_err_q;
`else
  assign parity_error  = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
`ifdef UART_PEER_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (!rxd_s_q) begin
            cnt_q   <= HALF_BIT;
            state_q <= START;
          end
        end
        START: begin
          if (!expire) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (rxd_s_q) begin
            state_q <= IDLE;
          end else begin
            cnt_q     <= FULL_BIT;
            bit_cnt_q <= '0;
`ifdef UART_PEER_PARITY_EN
            par_err_q <= 1'b0;
`endif
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (!expire) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            shift_q   <= {rxd_s_q, shift_q[UART_DATA_BITS-1:1]};
            cnt_q     <= FULL_BIT;
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_W'(UART_DATA_BITS - 1)) begin
`ifdef UART_PEER_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end
        end
`ifdef UART_PEER_PARITY_EN
        PARITY: begin
          if (!expire) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            par_err_q <= rxd_s_q ^ even_parity(shift_q);
            cnt_q     <= FULL_BIT;
            state_q   <= STOP;
          end
        end
`endif
        STOP: begin
          if (!expire) cnt_q <= cnt_q - CNT_W'(1);
          else         state_q <= rxd_s_q ? IDLE : WAIT_IDLE;
        end
        WAIT_IDLE: begin
          if (rxd_s_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  uart_peer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk         (clk),
    .n_rst       (n_rst),
    .push_i      (fifo_push),
    .push_data_i (shift_q),
    .pop_i       (valid & ready),
    .pop_data_o  (data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign valid = ~fifo_empty;

  // One slot stays free for a frame already in flight when rts drops.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) rts_q <= 1'b0;
    else        rts_q <= (fifo_count < PTR_W'(FIFO_DEPTH - 1));
  end

  assign rts = rts_q;

endmodule
